// File: rtl/movement_pkg.sv
// Shared command encoding and arbitration helper for the player-movement path.
// Command index order is also the issue priority (lowest index wins).
package movement_pkg;

    typedef enum logic [1:0] {
        CMD_FWD   = 2'd0,
        CMD_BWD   = 2'd1,
        CMD_LEFT  = 2'd2,
        CMD_RIGHT = 2'd3
    } move_cmd_t;

    localparam int NUM_CMDS = 4;

    // Matches the pos/dir/plane update depth of movement_control.
    localparam int MOVE_MIN_GAP = 3;

    function automatic move_cmd_t pick_cmd(input logic [NUM_CMDS-1:0] flags);
        move_cmd_t cmd;
        cmd = CMD_RIGHT;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (flags[i]) begin
                cmd = move_cmd_t'(i[1:0]);
            end
        end
        return cmd;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-FF synchroniser, debounce, rising-edge detect and auto-repeat.
// req_o is a one-cycle request on each debounced press and on each repeat tick.
module button_debouncer
    import movement_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic btn_in,
    output logic req_o
);

    localparam int DB_W    = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX < 1) ? 1 : $clog2(REP_MAX + 1);
    localparam bit REP_EN  = (REPEAT_DELAY != 0);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             req_q, req_d;
    logic             rise;
    logic             tick;

    always_comb begin
        sync1_d    = btn_in;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        cnt_d      = '0;
        deb_prev_d = deb_q;
        rise       = deb_q & ~deb_prev_q;
        tick       = 1'b0;
        rep_cnt_d  = '0;

        // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
        if (sync2_q != deb_q) begin
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Down-counter armed at press; a tick is suppressed on the release edge.
        if (REP_EN) begin
            if (rise) begin
                rep_cnt_d = REP_W'(REPEAT_DELAY);
            end else if (deb_q && (rep_cnt_q != '0)) begin
                if (rep_cnt_q == REP_W'(1)) begin
                    tick      = deb_d;
                    rep_cnt_d = REP_W'(REPEAT_PERIOD);
                end else begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                end
            end
        end

        req_d = rise | tick;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            rep_cnt_q  <= '0;
            req_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            req_q      <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/movement_pulse_gen.sv
// Turns four raw buttons into spaced, mutually exclusive one-cycle movement commands.
// Holds the sticky request flags, the fixed-priority arbiter and the inter-pulse gap counter.
module movement_pulse_gen
    import movement_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int MIN_GAP         = MOVE_MIN_GAP
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic btn_fwd_in,
    input  logic btn_bwd_in,
    input  logic btn_left_in,
    input  logic btn_right_in,
    output logic fwd_pulse,
    output logic bwd_pulse,
    output logic leftRot_pulse,
    output logic rightRot_pulse,
    output logic is_pulse
);

    localparam int GAP_W = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("movement_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("movement_pulse_gen: REPEAT_PERIOD must be >= 1");
    end
    if (MIN_GAP < 3) begin : g_bad_gap
        $error("movement_pulse_gen: MIN_GAP must be >= 3");
    end

    logic [NUM_CMDS-1:0] btn_raw;
    logic [NUM_CMDS-1:0] req;
    logic [NUM_CMDS-1:0] flags_q, flags_d;
    logic [NUM_CMDS-1:0] pulse_q, pulse_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    move_cmd_t           cmd;

    assign btn_raw[CMD_FWD]   = btn_fwd_in;
    assign btn_raw[CMD_BWD]   = btn_bwd_in;
    assign btn_raw[CMD_LEFT]  = btn_left_in;
    assign btn_raw[CMD_RIGHT] = btn_right_in;

    for (genvar i = 0; i < NUM_CMDS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_debouncer (
            .clk_in   (clk_in),
            .rst_in_n (rst_in_n),
            .btn_in   (btn_raw[i]),
            .req_o    (req[i])
        );
    end

    always_comb begin
        flags_d = flags_q;
        pulse_d = '0;
        gap_d   = gap_q;
        cmd     = pick_cmd(flags_q);

        if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end else if (|flags_q) begin
            flags_d[cmd] = 1'b0;
            pulse_d[cmd] = 1'b1;
            gap_d        = GAP_W'(MIN_GAP - 1);
        end

        // Applied after the clear so a request landing on its own issue cycle is kept.
        flags_d = flags_d | req;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            flags_q <= '0;
            pulse_q <= '0;
            gap_q   <= '0;
        end else begin
            flags_q <= flags_d;
            pulse_q <= pulse_d;
            gap_q   <= gap_d;
        end
    end

    assign fwd_pulse      = pulse_q[CMD_FWD];
    assign bwd_pulse      = pulse_q[CMD_BWD];
    assign leftRot_pulse  = pulse_q[CMD_LEFT];
    assign rightRot_pulse = pulse_q[CMD_RIGHT];
    assign is_pulse       = |pulse_q;

endmodule

// File: tb/tb_movement_pulse_gen.sv
// Directed bench for movement_pulse_gen with short timing parameters.
// Per-cycle drive vectors are {reset, right, left, bwd, fwd}; expected pulses are listed by cycle.
module tb_movement_pulse_gen;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 10;
    localparam int GAP = 3;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } ev_t;

    logic clk_in;
    logic rst_in_n;
    logic btn_fwd_in, btn_bwd_in, btn_left_in, btn_right_in;
    logic fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse, is_pulse;
    logic nr_fwd, nr_bwd, nr_left, nr_right, nr_is;
    logic [3:0] obs_vec;

    int   n_assert;
    int   n_fail;
    int   nr_right_cnt;
    ev_t  exp_q[$];
    logic [4:0] drive_q[$];

    assign obs_vec = {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse};

    movement_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .MIN_GAP         (GAP)
    ) dut (
        .clk_in         (clk_in),
        .rst_in_n       (rst_in_n),
        .btn_fwd_in     (btn_fwd_in),
        .btn_bwd_in     (btn_bwd_in),
        .btn_left_in    (btn_left_in),
        .btn_right_in   (btn_right_in),
        .fwd_pulse      (fwd_pulse),
        .bwd_pulse      (bwd_pulse),
        .leftRot_pulse  (leftRot_pulse),
        .rightRot_pulse (rightRot_pulse),
        .is_pulse       (is_pulse)
    );

    movement_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (0),
        .REPEAT_PERIOD   (RP),
        .MIN_GAP         (GAP)
    ) dut_nr (
        .clk_in         (clk_in),
        .rst_in_n       (rst_in_n),
        .btn_fwd_in     (btn_fwd_in),
        .btn_bwd_in     (btn_bwd_in),
        .btn_left_in    (btn_left_in),
        .btn_right_in   (btn_right_in),
        .fwd_pulse      (nr_fwd),
        .bwd_pulse      (nr_bwd),
        .leftRot_pulse  (nr_left),
        .rightRot_pulse (nr_right),
        .is_pulse       (nr_is)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_exp(input int cyc, input logic [3:0] vec);
        ev_t e;
        e.cyc = cyc;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Cycle c drives the inputs sampled by the c-th edge and checks the outputs it registers.
    task automatic scan(input string tag, input int n);
        logic [4:0] d;
        logic [3:0] exp_vec;
        for (int c = 0; c < n; c++) begin
            d = (c < drive_q.size()) ? drive_q[c] : 5'b00000;
            rst_in_n = ~d[4];
            {btn_right_in, btn_left_in, btn_bwd_in, btn_fwd_in} = d[3:0];
            step();
            exp_vec = 4'b0000;
            foreach (exp_q[i]) begin
                if (exp_q[i].cyc == c) exp_vec = exp_vec | exp_q[i].vec;
            end
            check($sformatf("%s c%0d pulses", tag, c), {28'd0, obs_vec}, {28'd0, exp_vec});
            check($sformatf("%s c%0d is_pulse", tag, c), {31'd0, is_pulse}, {31'd0, |exp_vec});
            if (nr_right === 1'b1) nr_right_cnt++;
        end
        drive_q.delete();
        exp_q.delete();
        rst_in_n = 1'b1;
        {btn_right_in, btn_left_in, btn_bwd_in, btn_fwd_in} = 4'b0000;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        nr_right_cnt = 0;
        rst_in_n     = 1'b0;
        {btn_right_in, btn_left_in, btn_bwd_in, btn_fwd_in} = 4'b1111;

        // Reset held with every button pressed: nothing may come out.
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("reset c%0d pulses", i), {28'd0, obs_vec}, 32'd0);
            check($sformatf("reset c%0d is_pulse", i), {31'd0, is_pulse}, 32'd0);
        end

        // Release with buttons still held: re-debounced, then priority order with gap.
        for (int c = 0; c < 12; c++) drive_q.push_back(5'b01111);
        add_exp(8, 4'b0001);
        add_exp(11, 4'b0010);
        add_exp(14, 4'b0100);
        add_exp(17, 4'b1000);
        scan("rst_release", 40);

        // Clean left press held 15 cycles.
        for (int c = 0; c < 15; c++) drive_q.push_back(5'b00100);
        add_exp(8, 4'b0100);
        scan("left_press", 40);

        // Three-cycle glitch is filtered out.
        for (int c = 0; c < 3; c++) drive_q.push_back(5'b00001);
        scan("fwd_glitch", 20);

        // Bounce then five stable cycles gives exactly one pulse.
        begin
            logic [9:0] pat;
            pat = 10'b1111101101;
            for (int c = 0; c < 10; c++) drive_q.push_back({4'b0000, pat[c]});
        end
        add_exp(13, 4'b0001);
        scan("fwd_bounce", 40);

        // All four pressed together.
        for (int c = 0; c < 6; c++) drive_q.push_back(5'b01111);
        add_exp(8, 4'b0001);
        add_exp(11, 4'b0010);
        add_exp(14, 4'b0100);
        add_exp(17, 4'b1000);
        scan("all_four", 40);

        // Right held 60 cycles: press pulse, then auto-repeat until release.
        nr_right_cnt = 0;
        for (int c = 0; c < 60; c++) drive_q.push_back(5'b01000);
        add_exp(8, 4'b1000);
        add_exp(28, 4'b1000);
        add_exp(38, 4'b1000);
        add_exp(48, 4'b1000);
        add_exp(58, 4'b1000);
        scan("right_repeat", 90);
        check("no_repeat_build right count", nr_right_cnt, 32'd1);

        // Bwd tapped so its request lands inside the gap after the fwd pulse.
        for (int c = 0; c < 8; c++) drive_q.push_back({3'b000, c >= 2, c < 6});
        add_exp(8, 4'b0001);
        add_exp(11, 4'b0010);
        scan("bwd_in_gap", 40);

        // Same sequence, but reset while the bwd request is pending.
        for (int c = 0; c < 12; c++) drive_q.push_back({c == 10 || c == 11, 2'b00, c >= 2 && c < 8, c < 6});
        add_exp(8, 4'b0001);
        scan("reset_pending", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
